// File: rtl/display_pkg.sv
// display_pkg: shared code constants, scan FSM states and the input code sanitiser
//   CODE_W=7, CODE_ZERO=10 ('0' glyph), CODE_DASH=11, CODE_MAX=11
//   scan_state_t {IDLE, DWELL, GAP}
//   sanitize(): maps codes outside 1..CODE_MAX to a dash
package display_pkg;
  localparam int CODE_W = 7;
  localparam logic [CODE_W-1:0] CODE_ZERO = 7'd10;
  localparam logic [CODE_W-1:0] CODE_DASH = 7'd11;
  localparam logic [CODE_W-1:0] CODE_MAX = 7'd11;
  typedef enum logic [1:0] {IDLE, DWELL, GAP} scan_state_t;
  function automatic logic [CODE_W-1:0] sanitize(input logic [CODE_W-1:0] c);
    return (c == '0 || c > CODE_MAX) ? CODE_DASH : c;
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter shared by dwell and gap timing
//   i_clk, i_rst_n (sync, active low)
//   i_load / i_value : reload the count (takes priority over counting)
//   o_tc             : high while the count sits at zero (terminal count)
module scan_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes one 7-segment decoder across NUM_DIGITS digits
//   i_clk, i_rst_n (sync, active low), i_enable (0 forces IDLE)
//   i_load_valid/o_load_ready/i_load_codes : code set handshake, committed at frame boundaries
//   i_blank_mask : live per-digit dark mask during dwell
//   o_digit_code, o_digit_en_n (active low), o_scan_idx, o_frame_start : registered scan outputs
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_enable,
  input  logic                           i_load_valid,
  output logic                           o_load_ready,
  input  logic [CODE_W*NUM_DIGITS-1:0]   i_load_codes,
  input  logic [NUM_DIGITS-1:0]          i_blank_mask,
  output logic [CODE_W-1:0]              o_digit_code,
  output logic [NUM_DIGITS-1:0]          o_digit_en_n,
  output logic [$clog2(NUM_DIGITS)-1:0]  o_scan_idx,
  output logic                           o_frame_start
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'((BLANK_CYCLES > 0 ? BLANK_CYCLES : 1) - 1);
  scan_state_t r_state, w_state;
  logic [IW-1:0] r_idx, w_idx;
  logic [CODE_W-1:0] r_bank [NUM_DIGITS];
  logic [CODE_W-1:0] r_pend [NUM_DIGITS];
  logic r_pend_full, r_frame_start;
  logic [CODE_W-1:0] r_code, w_code;
  logic [NUM_DIGITS-1:0] r_en_n, w_en_n;
  logic w_tc, w_wrap, w_commit, w_accept, w_load;
  scan_timer #(.W(CW)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_value (w_state == GAP ? GAP_LD : DWELL_LD),
    .o_tc    (w_tc)
  );
  always_comb begin
    w_state = r_state;
    w_idx = r_idx;
    w_wrap = 1'b0;
    if (!i_enable) begin
      w_state = IDLE;
      w_idx = '0;
    end else if (r_state == IDLE) begin
      w_state = DWELL;
      w_idx = '0;
    end else if (w_tc && r_state == GAP) begin
      w_state = DWELL;
    end else if (w_tc) begin
      w_state = BLANK_CYCLES == 0 ? DWELL : GAP;
      w_wrap = (r_idx == IW'(NUM_DIGITS - 1));
      w_idx = w_wrap ? '0 : r_idx + IW'(1);
    end
    // IDLE keeps the timer primed so every state entry starts from a fresh reload
    w_load = (r_state == IDLE) || w_tc;
    w_commit = r_pend_full && (w_wrap || r_state == IDLE);
    w_accept = i_load_valid && !r_pend_full;
    // on a commit edge the outgoing code must already come from the new bank
    w_code = w_commit ? r_pend[w_idx] : r_bank[w_idx];
    w_en_n = '1;
    if (w_state == DWELL) w_en_n[w_idx] = i_blank_mask[w_idx];
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_code <= CODE_ZERO;
      r_en_n <= '1;
      r_frame_start <= 1'b0;
      r_pend_full <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_bank[i] <= CODE_ZERO;
    end else begin
      r_state <= w_state;
      r_idx <= w_idx;
      r_code <= w_code;
      r_en_n <= w_en_n;
      r_frame_start <= w_state == DWELL && w_idx == '0 && (r_state != DWELL || r_idx != '0);
      if (w_commit) begin
        r_bank <= r_pend;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend_full <= 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) r_pend[i] <= sanitize(i_load_codes[CODE_W*i +: CODE_W]);
      end
    end
  assign o_load_ready = !r_pend_full;
  assign o_digit_code = r_code;
  assign o_digit_en_n = r_en_n;
  assign o_scan_idx = r_idx;
  assign o_frame_start = r_frame_start;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: random scan/load stimulus against a timeline reference model
module tb_display_scan_controller;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n, enable, load_valid;
  logic [27:0] load_codes;
  logic [3:0] blank_mask;
  logic rdy0, rdy1, fs0, fs1;
  logic [6:0] dc0, dc1;
  logic [3:0] en0, en1;
  logic [1:0] si0, si1;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [27:0] q0[$], q1[$];
  bit scan_m[2];
  int t_m[2];
  bit full_m[2];
  logic [27:0] bank_m[2], pend_m[2];
  always #5 clk = ~clk;
  display_scan_controller #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_load_valid(load_valid),
    .o_load_ready(rdy0), .i_load_codes(load_codes), .i_blank_mask(blank_mask),
    .o_digit_code(dc0), .o_digit_en_n(en0), .o_scan_idx(si0), .o_frame_start(fs0));
  display_scan_controller #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_load_valid(load_valid),
    .o_load_ready(rdy1), .i_load_codes(load_codes), .i_blank_mask(blank_mask),
    .o_digit_code(dc1), .o_digit_en_n(en1), .o_scan_idx(si1), .o_frame_start(fs1));
  function automatic logic [27:0] san(input logic [27:0] c);
    logic [27:0] r;
    logic [6:0] v;
    for (int i = 0; i < N; i++) begin
      v = c[7*i +: 7];
      r[7*i +: 7] = (v == 7'd0 || v > 7'd11) ? 7'd11 : v;
    end
    return r;
  endfunction
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[blank%0d] cyc=%0d got=%0h exp=%0h", name, k == 0 ? 2 : 0, cyc, act, exp);
  endtask
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        int per, fr, ph, d, idx;
        bit wrap, commit, accept, dwell;
        logic [3:0] en_e;
        per = D + (k == 0 ? 2 : 0);
        fr = N * per;
        if (!rst_n) begin
          scan_m[k] = 0;
          t_m[k] = 0;
          full_m[k] = 0;
          bank_m[k] = {4{7'd10}};
          if (k == 0) q0.delete(); else q1.delete();
        end else begin
          wrap = scan_m[k] && enable && (t_m[k] % fr == (N - 1) * per + D - 1);
          commit = full_m[k] && (wrap || !scan_m[k]);
          accept = load_valid && !full_m[k];
          if (commit) begin
            bank_m[k] = pend_m[k];
            full_m[k] = 0;
          end
          if (accept) begin
            full_m[k] = 1;
            if ((k == 0 ? q0.size() : q1.size()) == 0) chk("queue_has_load", k, 0, 1);
            else pend_m[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
          end
          if (!enable) scan_m[k] = 0;
          else if (scan_m[k]) t_m[k]++;
          else begin
            scan_m[k] = 1;
            t_m[k] = 0;
          end
        end
        en_e = 4'hF;
        idx = 0;
        ph = -1;
        if (scan_m[k]) begin
          ph = t_m[k] % fr;
          d = ph / per;
          dwell = (ph % per) < D;
          idx = dwell ? d : (d + 1) % N;
          if (dwell) en_e[d] = blank_mask[d];
        end
        chk("digit_code", k, k == 0 ? dc0 : dc1, bank_m[k][7*idx +: 7]);
        chk("digit_en_n", k, k == 0 ? en0 : en1, en_e);
        chk("scan_idx", k, k == 0 ? si0 : si1, idx);
        chk("frame_start", k, k == 0 ? fs0 : fs1, ph == 0);
        chk("load_ready", k, k == 0 ? rdy0 : rdy1, !full_m[k]);
      end
    end
  end
  task automatic drive(input bit r, input bit e, input bit v, input logic [27:0] c, input logic [3:0] m);
    @(negedge clk);
    rst_n = r;
    enable = e;
    load_valid = v && r;
    load_codes = c;
    blank_mask = m;
    if (load_valid && rdy0) q0.push_back(san(c));
    if (load_valid && rdy1) q1.push_back(san(c));
  endtask
  function automatic logic [27:0] rnd_codes();
    logic [27:0] c;
    for (int i = 0; i < N; i++) c[7*i +: 7] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 13));
    return c;
  endfunction
  initial begin : stim
    logic [3:0] m;
    int off_left;
    rst_n = 1'b0;
    enable = 1'b0;
    load_valid = 1'b0;
    load_codes = '0;
    blank_mask = '0;
    repeat (3) drive(0, 0, 0, '0, 4'h0);
    repeat (60) drive(1, 1, 0, '0, 4'h0);
    drive(1, 1, 1, {7'd4, 7'd3, 7'd2, 7'd1}, 4'h0);
    repeat (40) drive(1, 1, 0, '0, 4'h0);
    drive(1, 1, 1, {7'd5, 7'd127, 7'd12, 7'd0}, 4'h0);
    repeat (40) drive(1, 1, 0, '0, 4'h0);
    repeat (3) drive(1, 0, 0, '0, 4'h0);
    drive(1, 0, 1, {7'd9, 7'd8, 7'd7, 7'd6}, 4'h0);
    repeat (3) drive(1, 0, 0, '0, 4'h0);
    repeat (30) drive(1, 1, 0, '0, 4'h4);
    m = 4'h0;
    off_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) m = 4'($urandom_range(0, 15));
      if (off_left == 0 && $urandom_range(0, 149) == 0) off_left = $urandom_range(1, 6);
      if (off_left > 0) off_left--;
      drive(!(i >= 1500 && i < 1502), off_left == 0, $urandom_range(0, 9) == 0, rnd_codes(), m);
    end
    repeat (3) drive(1, 1, 0, '0, 4'h0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
